hpdmc_iodelay_ctl: RTL and testbench



---
 rtl/hpdmc_iodelay_ctl_if.sv | 27 ++
 rtl/hpdmc_iodelay_ctl.sv | 251 +++++++++++++++++++++++++
 tb/tb_hpdmc_iodelay_ctl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/hpdmc_iodelay_ctl_if.sv
// Command channel between the PHY control registers and the IODELAY2 sequencer.
interface hpdmc_iodelay_ctl_if #(
    parameter int LANES    = 16,
    parameter int TAP_BITS = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [LANES-1:0]    cmd_mask;
    logic [TAP_BITS-1:0] cmd_count;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_mask,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_mask,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/hpdmc_iodelay_ctl.sv
// IODELAY2 sequencing controller for the HPDMC DDR data path.
//
// state    | meaning
// ---------+----------------------------------------------------------
// INIT_CAL | after reset: launch the automatic CAL strobe
// INIT_RST | after init CAL settles: launch the automatic RST strobe
// IDLE     | cmd_ready high, waiting for a command
// CAL      | dly_cal strobe cycle
// RST      | dly_rst strobe cycle, shadow taps cleared
// STEP     | dly_ce strobe cycle, shadow taps move at its end
// GAP      | STEP_GAP idle cycles after a CE strobe
// WAIT     | BUSY_LAT blanking phase, then poll dly_busy with timeout
module hpdmc_iodelay_ctl #(
    parameter int LANES        = 16,
    parameter int TAP_BITS     = 8,
    parameter int TAP_MAX      = 255,
    parameter int STEP_GAP     = 4,
    parameter int BUSY_LAT     = 2,
    parameter int BUSY_TIMEOUT = 1023,
    localparam int SEL_W       = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    hpdmc_iodelay_ctl_if.slave  cmd,
    output logic                dly_cal,
    output logic                dly_rst,
    output logic                dly_inc,
    output logic [LANES-1:0]    dly_ce,
    input  logic                dly_busy,
    input  logic [SEL_W-1:0]    tap_sel,
    output logic [TAP_BITS-1:0] tap_value,
    output logic                init_done,
    output logic                timeout
);

    localparam int WAIT_MAX = (BUSY_TIMEOUT > BUSY_LAT) ? BUSY_TIMEOUT : BUSY_LAT;
    localparam int WCW      = $clog2(WAIT_MAX + 1);

    localparam logic [1:0] OP_CAL = 2'b00;
    localparam logic [1:0] OP_RST = 2'b01;
    localparam logic [1:0] OP_INC = 2'b10;

    typedef enum logic [2:0] {
        INIT_CAL, INIT_RST, IDLE, CAL, RST, STEP, GAP, WAIT
    } state_t;

    state_t              state_q, state_d;
    logic                dly_cal_q, dly_cal_d;
    logic                dly_rst_q, dly_rst_d;
    logic                dly_inc_q, dly_inc_d;
    logic [LANES-1:0]    dly_ce_q, dly_ce_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                init_done_q, init_done_d;
    logic                timeout_q, timeout_d;
    logic                init_stage_q, init_stage_d;
    logic [1:0]          op_q, op_d;
    logic [LANES-1:0]    mask_q, mask_d;
    logic [TAP_BITS-1:0] remain_q, remain_d;
    logic [3:0]          gap_q, gap_d;
    logic [WCW-1:0]      wait_cnt_q, wait_cnt_d;
    logic                wait_blank_q, wait_blank_d;
    logic [TAP_BITS-1:0] tap_q [LANES];
    logic [TAP_BITS-1:0] tap_d [LANES];
    logic                issue;
    logic                wait_load;
    logic [LANES-1:0]    eff;

    assign dly_cal       = dly_cal_q;
    assign dly_rst       = dly_rst_q;
    assign dly_inc       = dly_inc_q;
    assign dly_ce        = dly_ce_q;
    assign cmd.cmd_ready = cmd_ready_q;
    assign init_done     = init_done_q;
    assign timeout       = timeout_q;
    assign tap_value     = (int'(tap_sel) < LANES) ? tap_q[tap_sel] : '0;

    // Shadow taps: RST is shared by every lane so it clears all of them; a CE strobe moves only its lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            tap_d[l] = tap_q[l];
            if (state_q == RST) begin
                tap_d[l] = '0;
            end else if (state_q == STEP && dly_ce_q[l]) begin
                tap_d[l] = dly_inc_q ? tap_q[l] + TAP_BITS'(1) : tap_q[l] - TAP_BITS'(1);
            end
        end
    end

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d      = state_q;
        dly_cal_d    = 1'b0;
        dly_rst_d    = 1'b0;
        dly_inc_d    = 1'b0;
        dly_ce_d     = '0;
        init_done_d  = init_done_q;
        timeout_d    = timeout_q;
        init_stage_d = init_stage_q;
        op_d         = op_q;
        mask_d       = mask_q;
        remain_d     = remain_q;
        gap_d        = gap_q;
        wait_cnt_d   = wait_cnt_q;
        wait_blank_d = wait_blank_q;
        issue        = 1'b0;
        wait_load    = 1'b0;
        eff          = '0;

        case (state_q)
            INIT_CAL: begin
                dly_cal_d    = 1'b1;
                init_stage_d = 1'b0;
                state_d      = CAL;
            end
            INIT_RST: begin
                dly_rst_d    = 1'b1;
                init_stage_d = 1'b1;
                state_d      = RST;
            end
            IDLE: begin
                if (cmd.cmd_valid && cmd_ready_q) begin
                    timeout_d = 1'b0;
                    op_d      = cmd.cmd_op;
                    mask_d    = cmd.cmd_mask;
                    remain_d  = cmd.cmd_count;
                    if (cmd.cmd_op == OP_CAL) begin
                        dly_cal_d = 1'b1;
                        state_d   = CAL;
                    end else if (cmd.cmd_op == OP_RST) begin
                        dly_rst_d = 1'b1;
                        state_d   = RST;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            CAL, RST: begin
                wait_load = 1'b1;
                state_d   = WAIT;
            end
            STEP: begin
                if (STEP_GAP == 0) begin
                    issue = 1'b1;
                end else begin
                    gap_d   = 4'(STEP_GAP - 1);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    issue = 1'b1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            WAIT: begin
                if (wait_blank_q) begin
                    if (wait_cnt_q == '0) begin
                        wait_blank_d = 1'b0;
                        wait_cnt_d   = WCW'(BUSY_TIMEOUT - 1);
                    end else begin
                        wait_cnt_d = wait_cnt_q - WCW'(1);
                    end
                end else if (!dly_busy) begin
                    if (!init_done_q && !init_stage_q) begin
                        state_d = INIT_RST;
                    end else begin
                        state_d     = IDLE;
                        init_done_d = 1'b1;
                    end
                end else if (wait_cnt_q == '0) begin
                    // A stuck BUSY aborts the sequence; init counts as done so software can recover.
                    timeout_d   = 1'b1;
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - WCW'(1);
                end
            end
            default: state_d = INIT_CAL;
        endcase

        if (wait_load) begin
            if (BUSY_LAT > 0) begin
                wait_blank_d = 1'b1;
                wait_cnt_d   = WCW'(BUSY_LAT - 1);
            end else begin
                wait_blank_d = 1'b0;
                wait_cnt_d   = WCW'(BUSY_TIMEOUT - 1);
            end
        end

        // Saturated lanes drop out of the mask; the command ends once nothing is left to move.
        if (issue) begin
            for (int l = 0; l < LANES; l++) begin
                eff[l] = mask_d[l] && !((op_d == OP_INC) ? (tap_d[l] == TAP_BITS'(TAP_MAX))
                                                         : (tap_d[l] == '0));
            end
            if (remain_d == '0 || eff == '0) begin
                state_d = IDLE;
            end else begin
                dly_ce_d  = eff;
                dly_inc_d = (op_d == OP_INC);
                remain_d  = remain_d - TAP_BITS'(1);
                state_d   = STEP;
            end
        end

        cmd_ready_d = (state_d == IDLE);
    end

    // State, strobes, status and shadow taps; async reset restarts the init sequence.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= INIT_CAL;
            dly_cal_q    <= 1'b0;
            dly_rst_q    <= 1'b0;
            dly_inc_q    <= 1'b0;
            dly_ce_q     <= '0;
            cmd_ready_q  <= 1'b0;
            init_done_q  <= 1'b0;
            timeout_q    <= 1'b0;
            init_stage_q <= 1'b0;
            op_q         <= '0;
            mask_q       <= '0;
            remain_q     <= '0;
            gap_q        <= '0;
            wait_cnt_q   <= '0;
            wait_blank_q <= 1'b0;
            for (int l = 0; l < LANES; l++) tap_q[l] <= '0;
        end else begin
            state_q      <= state_d;
            dly_cal_q    <= dly_cal_d;
            dly_rst_q    <= dly_rst_d;
            dly_inc_q    <= dly_inc_d;
            dly_ce_q     <= dly_ce_d;
            cmd_ready_q  <= cmd_ready_d;
            init_done_q  <= init_done_d;
            timeout_q    <= timeout_d;
            init_stage_q <= init_stage_d;
            op_q         <= op_d;
            mask_q       <= mask_d;
            remain_q     <= remain_d;
            gap_q        <= gap_d;
            wait_cnt_q   <= wait_cnt_d;
            wait_blank_q <= wait_blank_d;
            for (int l = 0; l < LANES; l++) tap_q[l] <= tap_d[l];
        end
    end

endmodule

// File: tb/tb_hpdmc_iodelay_ctl.sv
// Directed bench for hpdmc_iodelay_ctl with default parameters.
module tb_hpdmc_iodelay_ctl;

    localparam int G = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        dly_cal, dly_rst, dly_inc;
    logic [15:0] dly_ce;
    logic        dly_busy = 1'b0;
    logic [3:0]  tap_sel = '0;
    logic [7:0]  tap_value;
    logic        init_done, timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, cal_cnt = 0, rst_cnt = 0, cal_cyc = 0, rst_cyc = 0, rdy_cyc = 0, overlap_cnt = 0;
    logic ready_prev = 1'b0;

    hpdmc_iodelay_ctl_if #(.LANES(16), .TAP_BITS(8)) cmd_if ();

    hpdmc_iodelay_ctl dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cmd       (cmd_if),
        .dly_cal   (dly_cal),
        .dly_rst   (dly_rst),
        .dly_inc   (dly_inc),
        .dly_ce    (dly_ce),
        .dly_busy  (dly_busy),
        .tap_sel   (tap_sel),
        .tap_value (tap_value),
        .init_done (init_done),
        .timeout   (timeout)
    );

    always #5 sys_clk = ~sys_clk;

    // Strobe bookkeeping sampled on the falling edge.
    always @(negedge sys_clk) begin
        cyc        <= cyc + 1;
        ready_prev <= cmd_if.cmd_ready;
        if (sys_rst_n) begin
            if (dly_cal) begin cal_cnt <= cal_cnt + 1; cal_cyc <= cyc; end
            if (dly_rst) begin rst_cnt <= rst_cnt + 1; rst_cyc <= cyc; end
            if (cmd_if.cmd_ready && !ready_prev) rdy_cyc <= cyc;
            if (int'(dly_cal) + int'(dly_rst) + int'(|dly_ce) > 1) overlap_cnt <= overlap_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int max_cyc, input string tag);
        int n = 0;
        @(negedge sys_clk);
        while (!cmd_if.cmd_ready && n < max_cyc) begin
            @(negedge sys_clk);
            n++;
        end
        check_eq(tag, cmd_if.cmd_ready, 1);
    endtask

    // Waits for ready, presents one command and leaves time just after the accepting edge (cycle N+1).
    task automatic send(input logic [1:0] op, input logic [15:0] mask, input logic [7:0] cnt);
        wait_ready(3000, "ready_before_cmd");
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_mask  = mask;
        cmd_if.cmd_count = cnt;
        @(posedge sys_clk);
        #1 cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic check_tap(input int lane, input logic [7:0] exp, input string tag);
        tap_sel = 4'(lane);
        #1 check_eq(tag, tap_value, exp);
    endtask

    // Watches cycles N+1..N+len: up to three pulses at N+1, N+1+(G+1), N+1+2(G+1); ready from ready_at on.
    task automatic observe(input int len, input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] p2, input logic inc_exp, input int ready_at);
        logic [15:0] exp_ce;
        for (int i = 1; i <= len; i++) begin
            @(negedge sys_clk);
            exp_ce = (i == 1) ? p0 : (i == 1 + (G + 1)) ? p1 : (i == 1 + 2 * (G + 1)) ? p2 : 16'h0;
            check_eq($sformatf("ce_c%0d", i), dly_ce, exp_ce);
            if (exp_ce != 16'h0) check_eq($sformatf("inc_c%0d", i), dly_inc, inc_exp);
            check_eq($sformatf("ready_c%0d", i), cmd_if.cmd_ready, i >= ready_at);
        end
    endtask

    task automatic do_init(input int busy_cycles, input int exp_rst_dly, input int exp_rdy_dly);
        int n = 0;
        int cal0, rst0;
        @(negedge sys_clk);
        cal0 = cal_cnt;
        rst0 = rst_cnt;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        while (!dly_cal && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        check_eq("init_cal_seen", dly_cal, 1);
        if (busy_cycles > 0) begin
            @(posedge sys_clk);
            #1 dly_busy = 1'b1;
            repeat (busy_cycles) @(posedge sys_clk);
            #1 dly_busy = 1'b0;
        end
        wait_ready(100, "init_ready");
        #1;
        check_eq("init_cal_pulses", 64'(cal_cnt - cal0), 1);
        check_eq("init_rst_pulses", 64'(rst_cnt - rst0), 1);
        check_eq("init_rst_delay", 64'(rst_cyc - cal_cyc), 64'(exp_rst_dly));
        check_eq("init_ready_delay", 64'(rdy_cyc - cal_cyc), 64'(exp_rdy_dly));
        check_eq("init_done", init_done, 1);
        check_eq("init_timeout", timeout, 0);
        for (int l = 0; l < 16; l++) check_tap(l, 8'd0, "init_tap");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_mask  = '0;
        cmd_if.cmd_count = '0;

        // Reset values.
        repeat (3) @(negedge sys_clk);
        check_eq("rst_cal", dly_cal, 0);
        check_eq("rst_rst", dly_rst, 0);
        check_eq("rst_ce", dly_ce, 0);
        check_eq("rst_inc", dly_inc, 0);
        check_eq("rst_ready", cmd_if.cmd_ready, 0);
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_timeout", timeout, 0);

        // Init with BUSY held for 10 cycles after the CAL strobe.
        do_init(10, 13, 17);

        // INC lanes 0,2 by 3.
        send(2'b10, 16'h0005, 8'd3);
        observe(16, 16'h0005, 16'h0005, 16'h0005, 1'b1, 16);
        check_tap(0, 8'd3, "inc_tap0");
        check_tap(1, 8'd0, "inc_tap1");
        check_tap(2, 8'd3, "inc_tap2");

        // Lane 0 to 254, then INC lanes 0,1 by 3: lane 0 saturates after one step.
        send(2'b10, 16'h0001, 8'd251);
        wait_ready(2000, "prefill_ready");
        check_tap(0, 8'd254, "prefill_tap0");
        send(2'b10, 16'h0003, 8'd3);
        observe(16, 16'h0003, 16'h0002, 16'h0002, 1'b1, 16);
        check_tap(0, 8'd255, "sat_tap0");
        check_tap(1, 8'd3, "sat_tap1");

        // RESET command: one RST strobe, ready at N+5, all taps zero.
        send(2'b01, 16'h0000, 8'd0);
        @(negedge sys_clk);
        check_eq("reset_strobe", dly_rst, 1);
        repeat (3) @(negedge sys_clk);
        check_eq("reset_ready_n4", cmd_if.cmd_ready, 0);
        @(negedge sys_clk);
        check_eq("reset_ready_n5", cmd_if.cmd_ready, 1);
        check_tap(0, 8'd0, "reset_tap0");
        check_tap(1, 8'd0, "reset_tap1");
        check_tap(2, 8'd0, "reset_tap2");

        // DEC on a lane already at 0: no strobe, ready stays up.
        send(2'b11, 16'h0001, 8'd5);
        observe(3, 16'h0, 16'h0, 16'h0, 1'b0, 1);
        check_tap(0, 8'd0, "dec_zero_tap0");

        // Lane 3 up by 2, then DEC by 5 ends early after two strobes.
        send(2'b10, 16'h0008, 8'd2);
        observe(11, 16'h0008, 16'h0008, 16'h0, 1'b1, 11);
        check_tap(3, 8'd2, "up_tap3");
        send(2'b11, 16'h0008, 8'd5);
        observe(11, 16'h0008, 16'h0008, 16'h0, 1'b0, 11);
        check_tap(3, 8'd0, "down_tap3");

        // CAL with BUSY stuck high: timeout after 1023 poll cycles.
        dly_busy = 1'b1;
        send(2'b00, 16'h0000, 8'd0);
        repeat (1026) @(negedge sys_clk);
        check_eq("to_ready_n1026", cmd_if.cmd_ready, 0);
        check_eq("to_flag_n1026", timeout, 0);
        @(negedge sys_clk);
        check_eq("to_ready_n1027", cmd_if.cmd_ready, 1);
        check_eq("to_flag_n1027", timeout, 1);
        dly_busy = 1'b0;

        // Next command clears timeout.
        send(2'b00, 16'h0000, 8'd0);
        @(negedge sys_clk);
        check_eq("cal_strobe", dly_cal, 1);
        check_eq("to_cleared", timeout, 0);
        repeat (3) @(negedge sys_clk);
        check_eq("cal_ready_n4", cmd_if.cmd_ready, 0);
        @(negedge sys_clk);
        check_eq("cal_ready_n5", cmd_if.cmd_ready, 1);

        // Reset during step 2 of a 5-step INC.
        send(2'b10, 16'hFFFF, 8'd5);
        @(negedge sys_clk);
        check_eq("mid_ce1", dly_ce, 16'hFFFF);
        repeat (5) @(negedge sys_clk);
        check_eq("mid_ce2", dly_ce, 16'hFFFF);
        check_tap(0, 8'd1, "mid_tap0");
        sys_rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ce", dly_ce, 0);
        check_eq("mid_rst_inc", dly_inc, 0);
        check_eq("mid_rst_ready", cmd_if.cmd_ready, 0);
        check_eq("mid_rst_init_done", init_done, 0);
        check_tap(0, 8'd0, "mid_rst_tap0");
        check_tap(15, 8'd0, "mid_rst_tap15");
        repeat (2) @(negedge sys_clk);
        do_init(0, 5, 9);

        check_eq("no_strobe_overlap", 64'(overlap_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
